// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: RV32I load/store funct3
// codes and the responder FSM state encoding.
package data_mem_responder_pkg;

    localparam logic [2:0] Funct3Lb  = 3'd0;
    localparam logic [2:0] Funct3Lh  = 3'd1;
    localparam logic [2:0] Funct3Lw  = 3'd2;
    localparam logic [2:0] Funct3Lbu = 3'd4;
    localparam logic [2:0] Funct3Lhu = 3'd5;
    localparam logic [2:0] Funct3Sb  = 3'd0;
    localparam logic [2:0] Funct3Sh  = 3'd1;
    localparam logic [2:0] Funct3Sw  = 3'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: load extraction/extension, store
// byte enables and data placement. DMEM_MISALIGN_TRAP_EN turns misalignment into an error.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [31:0] load_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_data,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        supported;
    logic        misaligned;

    assign byte_sel = mem_word[{byte_off, 3'b000} +: 8];
    assign half_sel = mem_word[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((funct3 == Funct3Lh || funct3 == Funct3Lhu) && byte_off[0]) ||
                     (funct3 == Funct3Lw && byte_off != 2'b00);
`else
        misaligned = 1'b0;
`endif
    end

    always_comb begin
        load_data  = '0;
        store_be   = '0;
        store_data = '0;
        supported  = 1'b0;
        if (we) begin
            case (funct3)
                Funct3Sb: begin
                    supported  = 1'b1;
                    store_be   = 4'b0001 << byte_off;
                    store_data = {4{wdata[7:0]}};
                end
                Funct3Sh: begin
                    supported  = 1'b1;
                    store_be   = byte_off[1] ? 4'b1100 : 4'b0011;
                    store_data = {2{wdata[15:0]}};
                end
                Funct3Sw: begin
                    supported  = 1'b1;
                    store_be   = 4'b1111;
                    store_data = wdata;
                end
                default: ;
            endcase
        end else begin
            supported = 1'b1;
            case (funct3)
                Funct3Lb:  load_data = {{24{byte_sel[7]}}, byte_sel};
                Funct3Lbu: load_data = {24'h0, byte_sel};
                Funct3Lh:  load_data = {{16{half_sel[15]}}, half_sel};
                Funct3Lhu: load_data = {16'h0, half_sel};
                Funct3Lw:  load_data = mem_word;
                default:   supported = 1'b0;
            endcase
        end
        err = !supported || misaligned;
        if (err) begin
            load_data = '0;
            store_be  = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with fixed-latency response over word-organised storage.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (reject misaligned half/word accesses).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = 4'(LATENCY - 1);

    dmem_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q;
    logic [IdxW+1:0]  addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       funct3_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             acc_we;
    logic [IdxW+1:0]  acc_addr;
    logic [31:0]      acc_wdata;
    logic [2:0]       acc_funct3;
    logic [31:0]      mem_word;
    logic [31:0]      load_data;
    logic [31:0]      store_data;
    logic [3:0]       store_be;
    logic             acc_err;
    logic             unused_addr;

    assign unused_addr = ^req_addr[31:IdxW+2];
    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign accept      = req_valid && req_ready;

    // With zero latency the access happens on the accepting edge, before the latch is loaded.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we     = req_we;
            acc_addr   = req_addr[IdxW+1:0];
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_we     = we_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
            acc_funct3 = funct3_q;
        end
    end

    assign mem_word = mem_q[acc_addr[IdxW+1:2]];

    dmem_lane_align u_lane_align (
        .we         (acc_we),
        .byte_off   (acc_addr[1:0]),
        .funct3     (acc_funct3),
        .wdata      (acc_wdata),
        .mem_word   (mem_word),
        .load_data  (load_data),
        .store_be   (store_be),
        .store_data (store_data),
        .err        (acc_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                rsp_rdata_q <= acc_we ? '0 : load_data;
                rsp_err_q   <= acc_err;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst && accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr[IdxW+1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
        end
    end

    // Storage is deliberately outside reset: contents survive Rst.
    always_ff @(posedge Clk) begin
        if (!Rst && enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (store_be[i]) begin
                    mem_q[acc_addr[IdxW+1:2]][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

endmodule
